// File: rtl/bus_arbiter.sv
// 65C02 bus arbiter: CPU/DMA ownership, wait states for slow peripheral windows, bounded DMA bursts.
// Optional stall-cycle counter enabled by defining BUS_ARB_PERF_EN.
module bus_arbiter #(
  parameter int unsigned WS_ACIA       = 1,
  parameter int unsigned WS_VIA        = 3,
  parameter int unsigned DMA_MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        resb,
  input  logic [15:0] cpu_ab,
  input  logic        cpu_we,
  input  logic [7:0]  cpu_do,
  output logic        cpu_rdy,
  input  logic        dma_req,
  input  logic [15:0] dma_ab,
  input  logic        dma_we,
  input  logic [7:0]  dma_do,
  output logic        dma_gnt,
  output logic        dma_ack,
  output logic [15:0] bus_ab,
  output logic        bus_we,
  output logic [7:0]  bus_do,
  output logic [15:0] stall_cnt
);

  typedef enum logic [2:0] {
    ST_CPU_RUN  = 3'd0,
    ST_CPU_WAIT = 3'd1,
    ST_HANDOFF  = 3'd2,
    ST_DMA_RUN  = 3'd3,
    ST_DMA_WAIT = 3'd4,
    ST_RETURN   = 3'd5
  } state_t;

  localparam logic [2:0] WS_ACIA_L  = 3'(WS_ACIA);
  localparam logic [2:0] WS_VIA_L   = 3'(WS_VIA);
  localparam logic [7:0] BURST_LAST = 8'(DMA_MAX_BURST - 1);

  // Wait states for an address; zero means the access completes in one cycle.
  function automatic logic [2:0] ws_lookup(input logic [15:0] addr);
    logic [2:0] ws;
    ws = 3'd0;
    if (addr[15:4] == 12'h800) begin
      ws = WS_ACIA_L;
    end else if (addr[15:4] == 12'h880) begin
      ws = WS_VIA_L;
    end else begin
      ws = 3'd0;
    end
    return ws;
  endfunction

  state_t      state_r;
  state_t      state_s;
  logic [2:0]  wait_cnt_r;
  logic [2:0]  wait_cnt_s;
  logic [7:0]  burst_cnt_r;
  logic [7:0]  burst_cnt_s;
  logic        dma_gnt_r;
  logic        skip_req_r;
  logic        rdy_fsm_s;
  logic        ack_fsm_s;
  logic        cpu_rdy_s;
  logic        dma_ack_s;
  logic [15:0] bus_ab_s;
  logic        bus_we_s;
  logic [7:0]  bus_do_s;
  logic [2:0]  ws_s;
  logic        slow_hit_s;
  logic        dma_stop_s;
  logic [7:0]  burst_inc_s;

  // Bus owner mux; turnaround states suppress writes.
  always_comb begin
    bus_ab_s = cpu_ab;
    bus_we_s = cpu_we;
    bus_do_s = cpu_do;
    case (state_r)
      ST_CPU_RUN, ST_CPU_WAIT: begin
        bus_ab_s = cpu_ab;
        bus_we_s = cpu_we;
        bus_do_s = cpu_do;
      end
      ST_HANDOFF: begin
        bus_ab_s = cpu_ab;
        bus_we_s = 1'b0;
        bus_do_s = cpu_do;
      end
      ST_DMA_RUN, ST_DMA_WAIT: begin
        bus_ab_s = dma_ab;
        bus_we_s = dma_we;
        bus_do_s = dma_do;
      end
      ST_RETURN: begin
        bus_ab_s = dma_ab;
        bus_we_s = 1'b0;
        bus_do_s = dma_do;
      end
      default: begin
        bus_ab_s = cpu_ab;
        bus_we_s = cpu_we;
        bus_do_s = cpu_do;
      end
    endcase
  end

  // Access classification and burst bookkeeping helpers.
  always_comb begin
    ws_s        = ws_lookup(bus_ab_s);
    slow_hit_s  = (ws_s != 3'd0);
    dma_stop_s  = (!dma_req) || (burst_cnt_r >= BURST_LAST);
    burst_inc_s = (burst_cnt_r == 8'hFF) ? burst_cnt_r : (burst_cnt_r + 8'd1);
  end

  // Next-state, counters, RDY and DMA acknowledge.
  always_comb begin
    state_s     = state_r;
    wait_cnt_s  = wait_cnt_r;
    burst_cnt_s = burst_cnt_r;
    rdy_fsm_s   = 1'b0;
    ack_fsm_s   = 1'b0;
    case (state_r)
      ST_CPU_RUN: begin
        if (slow_hit_s) begin
          wait_cnt_s = ws_s - 3'd1;
          state_s    = ST_CPU_WAIT;
        end else if (dma_req && !skip_req_r) begin
          state_s = ST_HANDOFF;
        end else begin
          rdy_fsm_s = 1'b1;
        end
      end
      ST_CPU_WAIT: begin
        if (wait_cnt_r != 3'd0) begin
          wait_cnt_s = wait_cnt_r - 3'd1;
        end else begin
          rdy_fsm_s = 1'b1;
          state_s   = ST_CPU_RUN;
        end
      end
      ST_HANDOFF: begin
        burst_cnt_s = 8'd0;
        state_s     = ST_DMA_RUN;
      end
      ST_DMA_RUN: begin
        burst_cnt_s = burst_inc_s;
        if (slow_hit_s) begin
          wait_cnt_s = ws_s - 3'd1;
          state_s    = ST_DMA_WAIT;
        end else begin
          ack_fsm_s = 1'b1;
          state_s   = dma_stop_s ? ST_RETURN : ST_DMA_RUN;
        end
      end
      ST_DMA_WAIT: begin
        burst_cnt_s = burst_inc_s;
        if (wait_cnt_r != 3'd0) begin
          wait_cnt_s = wait_cnt_r - 3'd1;
        end else begin
          ack_fsm_s = 1'b1;
          state_s   = dma_stop_s ? ST_RETURN : ST_DMA_RUN;
        end
      end
      ST_RETURN: begin
        state_s = ST_CPU_RUN;
      end
      default: begin
        state_s = ST_CPU_RUN;
      end
    endcase
  end

  // While reset is held the CPU is released and no DMA access is acknowledged.
  always_comb begin
    if (resb) begin
      cpu_rdy_s = rdy_fsm_s;
      dma_ack_s = ack_fsm_s;
    end else begin
      cpu_rdy_s = 1'b1;
      dma_ack_s = 1'b0;
    end
  end

  // State, counters, grant and the one-cycle post-burst request mask.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      state_r     <= ST_CPU_RUN;
      wait_cnt_r  <= 3'd0;
      burst_cnt_r <= 8'd0;
      dma_gnt_r   <= 1'b0;
      skip_req_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      wait_cnt_r  <= wait_cnt_s;
      burst_cnt_r <= burst_cnt_s;
      dma_gnt_r   <= (state_s == ST_DMA_RUN) || (state_s == ST_DMA_WAIT);
      skip_req_r  <= (state_r == ST_RETURN);
    end
  end

`ifdef BUS_ARB_PERF_EN
  logic [15:0] stall_cnt_r;

  // Saturating count of cycles the CPU is held off the bus.
  always_ff @(posedge clk or negedge resb) begin
    if (!resb) begin
      stall_cnt_r <= 16'h0000;
    end else if (!cpu_rdy_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt = stall_cnt_r;
`else
  assign stall_cnt = 16'h0000;
`endif

  assign cpu_rdy = cpu_rdy_s;
  assign dma_ack = dma_ack_s;
  assign dma_gnt = dma_gnt_r;
  assign bus_ab  = bus_ab_s;
  assign bus_we  = bus_we_s;
  assign bus_do  = bus_do_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: per-cycle comparison against an access-level model,
// plus literal expectations for the slow-window, burst, preemption and reset scenarios.
module tb_bus_arbiter;

  localparam int WS_A = 1;
  localparam int WS_V = 3;
  localparam int MAXB = 16;
`ifdef BUS_ARB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resb;
  logic [15:0] cpu_ab;
  logic        cpu_we;
  logic [7:0]  cpu_do;
  logic        cpu_rdy;
  logic        dma_req;
  logic [15:0] dma_ab;
  logic        dma_we;
  logic [7:0]  dma_do;
  logic        dma_gnt;
  logic        dma_ack;
  logic [15:0] bus_ab;
  logic        bus_we;
  logic [7:0]  bus_do;
  logic [15:0] stall_cnt;

  int total = 0;
  int bad   = 0;

  bus_arbiter #(.WS_ACIA(WS_A), .WS_VIA(WS_V), .DMA_MAX_BURST(MAXB)) dut (
    .clk(clk), .resb(resb),
    .cpu_ab(cpu_ab), .cpu_we(cpu_we), .cpu_do(cpu_do), .cpu_rdy(cpu_rdy),
    .dma_req(dma_req), .dma_ab(dma_ab), .dma_we(dma_we), .dma_do(dma_do),
    .dma_gnt(dma_gnt), .dma_ack(dma_ack),
    .bus_ab(bus_ab), .bus_we(bus_we), .bus_do(bus_do), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input logic [15:0] a);
    if (a >= 16'h8000 && a <= 16'h800F) return WS_A;
    else if (a >= 16'h8800 && a <= 16'h880F) return WS_V;
    else return 0;
  endfunction

  // Model phases: who owns the bus and what kind of cycle it is.
  localparam int P_IDLE = 0, P_CSLOW = 1, P_TURN = 2, P_DMA = 3, P_RET = 4;
  int m_phase  = P_IDLE;
  int m_el     = 0;   // cycles already spent in the current access
  int m_acc_ws = 0;
  int m_burst  = 0;   // DMA cycles already spent in this burst
  bit m_after  = 1'b0;
  int m_stall  = 0;

  task automatic model_cycle();
    logic [15:0] e_ab;
    logic        e_we;
    logic [7:0]  e_do;
    logic        e_rdy;
    logic        e_gnt;
    logic        e_ack;
    int          ws;
    if (!resb) begin
      chk("rst_rdy", {31'd0, cpu_rdy}, 32'd1);
      chk("rst_gnt", {31'd0, dma_gnt}, 32'd0);
      chk("rst_ack", {31'd0, dma_ack}, 32'd0);
      chk("rst_stall", {16'd0, stall_cnt}, 32'd0);
      chk("rst_bus_ab", {16'd0, bus_ab}, {16'd0, cpu_ab});
      m_phase = P_IDLE; m_el = 0; m_acc_ws = 0; m_burst = 0; m_after = 1'b0; m_stall = 0;
    end else begin
      e_rdy = 1'b0; e_gnt = 1'b0; e_ack = 1'b0;
      if (m_phase == P_IDLE || m_phase == P_CSLOW || m_phase == P_TURN) begin
        e_ab = cpu_ab; e_we = cpu_we; e_do = cpu_do;
      end else begin
        e_ab = dma_ab; e_we = dma_we; e_do = dma_do;
      end
      if (m_phase == P_TURN || m_phase == P_RET) e_we = 1'b0;
      ws = ws_of(e_ab);
      case (m_phase)
        P_IDLE: begin
          if (ws > 0) begin
            m_acc_ws = ws; m_el = 1; m_phase = P_CSLOW;
          end else if (dma_req && !m_after) begin
            m_phase = P_TURN;
          end else begin
            e_rdy = 1'b1;
          end
          m_after = 1'b0;
        end
        P_CSLOW: begin
          if (m_el == m_acc_ws) begin
            e_rdy = 1'b1; m_phase = P_IDLE;
          end else begin
            m_el = m_el + 1;
          end
        end
        P_TURN: begin
          m_phase = P_DMA; m_burst = 0; m_el = 0;
        end
        P_DMA: begin
          e_gnt = 1'b1;
          if (m_el == 0) m_acc_ws = ws;
          if (m_el == m_acc_ws) begin
            e_ack = 1'b1;
            if (!dma_req || m_burst >= MAXB - 1) m_phase = P_RET;
            m_el = 0;
          end else begin
            m_el = m_el + 1;
          end
          if (m_burst < 255) m_burst = m_burst + 1;
        end
        default: begin
          m_phase = P_IDLE; m_after = 1'b1;
        end
      endcase
      chk("bus_ab", {16'd0, bus_ab}, {16'd0, e_ab});
      chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
      chk("bus_do", {24'd0, bus_do}, {24'd0, e_do});
      chk("cpu_rdy", {31'd0, cpu_rdy}, {31'd0, e_rdy});
      chk("dma_gnt", {31'd0, dma_gnt}, {31'd0, e_gnt});
      chk("dma_ack", {31'd0, dma_ack}, {31'd0, e_ack});
      chk("stall_cnt", {16'd0, stall_cnt}, PERF ? m_stall : 32'd0);
      if (!e_rdy && m_stall < 65535) m_stall = m_stall + 1;
    end
  endtask

  always @(negedge clk) model_cycle();

  task automatic to_next();
    @(posedge clk);
    #1;
  endtask

  int          lows, gnt_n, ack_n, hi_n, we_n, do_n;
  logic        got_ack;
  logic [10:0] rdy_v, gnt_v, ack_v;
  logic [1:0]  rdy2_v;

  initial begin
    resb = 1'b0; cpu_ab = 16'h1000; cpu_we = 1'b0; cpu_do = 8'h00;
    dma_req = 1'b0; dma_ab = 16'h0200; dma_we = 1'b0; dma_do = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("lit_reset_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("lit_reset_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("lit_reset_stall", {16'd0, stall_cnt}, 32'd0);
    resb = 1'b1;
    to_next(); to_next();

    // Three back-to-back VIA reads at $8804.
    cpu_ab = 16'h8804; lows = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!cpu_rdy) lows = lows + 1;
      if (i == 3) begin
        chk("lit_via_first_lows", lows, 32'd3);
        chk("lit_via_done_rdy", {31'd0, cpu_rdy}, 32'd1);
      end
      to_next();
    end
    chk("lit_via3_lows", lows, 32'd9);
    cpu_ab = 16'h1000;
    @(negedge clk);
    chk("lit_stall_after_via3", {16'd0, stall_cnt}, PERF ? 32'd9 : 32'd0);
    to_next();

    // DMA burst to RAM held for 40 cycles.
    dma_ab = 16'h0200; dma_we = 1'b1; dma_do = 8'h3C; dma_req = 1'b1;
    gnt_n = 0; ack_n = 0; hi_n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      gnt_n = gnt_n + int'(dma_gnt);
      ack_n = ack_n + int'(dma_ack);
      hi_n  = hi_n + int'(cpu_rdy);
      got_ack = dma_ack;
      if (i == 19) begin
        chk("lit_burst1_gnt", gnt_n, 32'd16);
        chk("lit_burst1_ack", ack_n, 32'd16);
      end
      to_next();
      if (got_ack) dma_ab = dma_ab + 16'd1;
    end
    chk("lit_bursts_gnt", gnt_n, 32'd32);
    chk("lit_bursts_ack", ack_n, 32'd32);
    chk("lit_bursts_rdy_hi", hi_n, 32'd2);
    dma_we = 1'b0;

    // DMA request arrives with a CPU VIA access; DMA then hits the VIA too and drops req mid-wait.
    cpu_ab = 16'h8804; dma_ab = 16'h8802; dma_req = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 4) cpu_ab = 16'h1000;
      if (i == 7) dma_req = 1'b0;
      @(negedge clk);
      rdy_v[10-i] = cpu_rdy;
      gnt_v[10-i] = dma_gnt;
      ack_v[10-i] = dma_ack;
      to_next();
    end
    chk("lit_preempt_rdy", {21'd0, rdy_v}, {21'd0, 11'b00010000000});
    chk("lit_preempt_gnt", {21'd0, gnt_v}, {21'd0, 11'b00000011110});
    chk("lit_preempt_ack", {21'd0, ack_v}, {21'd0, 11'b00000000010});

    // Reset asserted in the middle of a DMA wait.
    dma_ab = 16'h8802; dma_req = 1'b1; cpu_ab = 16'h1000;
    repeat (4) to_next();
    #2;
    resb = 1'b0;
    #1;
    chk("lit_midrst_gnt", {31'd0, dma_gnt}, 32'd0);
    chk("lit_midrst_rdy", {31'd0, cpu_rdy}, 32'd1);
    chk("lit_midrst_ab", {16'd0, bus_ab}, 32'h0000_1000);
    chk("lit_midrst_stall", {16'd0, stall_cnt}, 32'd0);
    to_next();
    resb = 1'b1; dma_req = 1'b0;

    // ACIA write at $8001.
    cpu_ab = 16'h8001; cpu_we = 1'b1; cpu_do = 8'hA5; we_n = 0; do_n = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      rdy2_v[1-i] = cpu_rdy;
      we_n = we_n + int'(bus_we);
      if (bus_do == 8'hA5) do_n = do_n + 1;
      to_next();
    end
    chk("lit_acia_rdy", {30'd0, rdy2_v}, {30'd0, 2'b01});
    chk("lit_acia_we", we_n, 32'd2);
    chk("lit_acia_do", do_n, 32'd2);
    cpu_ab = 16'h1000; cpu_we = 1'b0;
    @(negedge clk);
    chk("lit_stall_after_acia", {16'd0, stall_cnt}, PERF ? 32'd1 : 32'd0);
    to_next(); to_next(); to_next();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Sequences the 65C02 system bus between the CPU and one DMA requester.
- Inserts programmable wait states for the slow ACIA ($8000-$800F) and VIA ($8800-$880F) windows by pulling CPU RDY low.
- Grants the bus to DMA in bounded bursts.
- Sits between cpu_65c02 and the address decode / RAM / ROM / ACIA / VIA fabric, and drives the shared address, write-enable and write-data lines.

Parameters:
WS_ACIA, 1, extra cycles added to each access in $8000-$800F (0-7)
WS_VIA, 3, extra cycles added to each access in $8800-$880F (0-7)
DMA_MAX_BURST, 16, maximum consecutive DMA-owned cycles before a forced return to the CPU (2-255)

Ports:
clk  in  1  system clock (same as phi2)
resb  in  1  asynchronous active-low reset
cpu_ab  in  16  CPU address
cpu_we  in  1  CPU write enable
cpu_do  in  8  CPU write data
cpu_rdy  out  1  to CPU RDY; 0 stalls the CPU
dma_req  in  1  DMA bus request, level
dma_ab  in  16  DMA address
dma_we  in  1  DMA write enable
dma_do  in  8  DMA write data
dma_gnt  out  1  DMA owns the bus
dma_ack  out  1  one-cycle pulse: the current DMA access completes this cycle
bus_ab  out  16  shared address to decode/memories
bus_we  out  1  shared write enable
bus_do  out  8  shared write data
stall_cnt  out  16  CPU stall-cycle count (optional feature)

Behaviour:
Reset, resb low (asynchronous):
- state=CPU_RUN; wait counter=0; burst counter=0.
- dma_gnt=0, dma_ack=0, stall_cnt=0.
- cpu_rdy=1.

Bus mux (combinational on state):
- CPU owner (CPU_RUN, CPU_WAIT, HANDOFF): bus_ab/we/do = cpu_*. In HANDOFF, bus_we is forced to 0.
- DMA owner (DMA_RUN, DMA_WAIT, RETURN): bus_ab/we/do = dma_*. In RETURN, bus_we is forced to 0.

Slow hit:
- Defined as bus_ab inside the ACIA or VIA window with that window's WS > 0.
- WS for the access = the matching window parameter.

CPU_RUN (cpu_rdy combinational):
- Slow hit: cpu_rdy=0 in this same cycle; load wait counter=WS-1 (WS=1 is done immediately); go to CPU_WAIT.
- No slow hit and dma_req=1: cpu_rdy=0; go to HANDOFF.
- Slow hit takes precedence over dma_req.

CPU_WAIT:
- cpu_rdy=0 while the counter is nonzero; counter decrements each cycle.
- Counter==0: cpu_rdy=1 (CPU completes the access); next state CPU_RUN.
- A slow access therefore occupies exactly WS+1 cycles with bus_ab stable throughout.

HANDOFF:
- One turnaround cycle; cpu_rdy=0.
- Next state: DMA_RUN, with dma_gnt=1 registered from the next cycle and burst counter cleared.

DMA_RUN / DMA_WAIT:
- cpu_rdy=0 throughout.
- Each DMA access obeys the same wait-state rule. dma_ack=1 in the final cycle of each access (the first cycle if there is no slow hit).
- The CPU never sees bus_ab changes because RDY is held low.
- Burst counter increments every DMA-owned cycle.
- Leave DMA_RUN for RETURN at an access boundary when dma_req=0, or when burst counter ≥ DMA_MAX_BURST-1.
- dma_req dropping mid-wait does not abort the access: it completes and is acked.

RETURN:
- One cycle; dma_gnt=0; cpu_rdy=0.
- Next state CPU_RUN.
- The following CPU_RUN cycle ignores dma_req, guaranteeing at least one CPU access (one cpu_rdy=1 cycle) between bursts.

Simultaneous events:
- dma_req asserting during CPU_WAIT is held off until the CPU access completes.

Counters:
- Wait counter is 3 bits and never wraps.
- Burst counter is 8 bits and saturates.

Optional Feature:
BUS_ARB_PERF_EN
- Defined: stall_cnt is a 16-bit saturating counter that increments every cycle cpu_rdy=0 (holds at 16'hFFFF) and clears only on reset.
- Undefined: stall_cnt is tied to 16'h0000 and no counter logic is built.

Test Plan:
- CPU read of $8804 (VIA, WS_VIA=3) -> cpu_rdy low for exactly 3 cycles starting the cycle bus_ab=$8804; 4 total cycles; bus_ab stable; then returns to CPU_RUN.
- CPU write of $8001 (ACIA, WS_ACIA=1) -> cpu_rdy low 1 cycle; bus_we=1 and bus_do=cpu_do held for 2 cycles.
- dma_req held high for 40 cycles, DMA_MAX_BURST=16, DMA to RAM $0200+ -> dma_gnt high 16 cycles, 1-cycle RETURN, exactly 1 cpu_rdy=1 cycle, HANDOFF, regrant; 16 dma_ack pulses per burst.
- dma_req asserted in the same cycle as a CPU VIA access -> VIA access completes in full (3 wait cycles), then HANDOFF, then dma_gnt=1.
- resb pulsed low mid DMA_WAIT -> immediately dma_gnt=0, cpu_rdy=1, bus_ab=cpu_ab, stall_cnt=0.
- With BUS_ARB_PERF_EN, three VIA reads -> stall_cnt=9; without the macro -> stall_cnt=0.
